pipeline_dest_tracker: RTL
==========================

Name: pipeline_dest_tracker

Overview:
- Sequential producer of the destination-register tags that the hazards/forwarding unit consumes.
- Carries each decoded instruction's Rd, RF-enable and load flag through the ID/EX, EX/MEM and MEM/WB slots.
- Applies NOP insertion, branch flush and data-memory wait freezes to those slots.
- Also exports a pending-write register mask and a saturating bubble counter.

Parameters:
- REG_ADDR_W, 4, register address width; 16 architectural registers.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- id_rd  input  REG_ADDR_W  destination register decoded in ID.
- id_rf_enable  input  1  ID instruction writes the register file.
- id_load  input  1  ID instruction is a load.
- id_valid  input  1  ID slot holds a real instruction.
- nop_insertion  input  1  load-use NOP select from the hazards/forwarding unit.
- flush  input  1  taken branch; kill the ID instruction.
- mem_busy  input  1  data memory not ready this cycle.
- ex_rd  output  REG_ADDR_W  EX-slot destination register.
- ex_rf_enable  output  1  EX-slot write enable.
- ex_load_instruction  output  1  EX-slot load flag.
- mem_rd  output  REG_ADDR_W  MEM-slot destination register.
- mem_rf_enable  output  1  MEM-slot write enable.
- wb_rd  output  REG_ADDR_W  WB-slot destination register.
- wb_rf_enable  output  1  WB-slot write enable.
- pending_mask  output  16  bit r set if any enabled slot targets register r.
- pipe_freeze  output  1  EX/MEM slots held this cycle.
- bubble_count  output  CNT_W  cycles in which a load-use bubble entered EX.

Behaviour:
- Reset (reset_n=0, asynchronous): all slot fields 0, so every rd is 0 and every enable/load flag is 0; bubble_count is 0.
- Slot outputs are registered. An instruction presented in ID at edge N appears on ex_* after edge N, on mem_* after edge N+1, and on wb_* after edge N+2, given no freeze.
- Bubble: rd=0, rf_enable=0, load=0.
- Each rising edge with mem_busy=0:
  - EX <= bubble if (nop_insertion | flush | !id_valid), else {id_rd, id_rf_enable, id_load}.
  - MEM <= {ex_rd, ex_rf_enable}; the load flag is not carried.
  - WB <= MEM.
- Each rising edge with mem_busy=1:
  - EX and MEM hold their contents.
  - WB <= bubble, so the WB instruction retires once and is not repeated.
  - nop_insertion and flush are ignored that edge. The upstream IF/ID register is also frozen, so the ID instruction is re-presented.
- Priority order: mem_busy > (flush | nop_insertion) > normal advance. flush and nop_insertion together produce a single bubble.
- pipe_freeze = mem_busy, combinational pass-through.
- pending_mask: combinational OR of the one-hot decode of ex_rd gated by ex_rf_enable, mem_rd gated by mem_rf_enable, and wb_rd gated by wb_rf_enable. All slots targeting the same register set one bit. Register 15 (PC) is tracked like any other register.
- bubble_count: increments by 1 on an edge where nop_insertion=1 and mem_busy=0. It saturates at all-ones with no wrap. flush-only bubbles and !id_valid bubbles are not counted.
- Reset mid-operation: slots clear immediately (asynchronously) and in-flight tags are discarded. The first post-reset edge loads EX normally.
- Never emit rf_enable=1 with a stale rd; enables and rd always move together.

Test Plan:
- Reset, then ID {rd=3, en=1, load=0} for 1 cycle followed by id_valid=0 → ex_rd=3/en=1 after edge 1; mem_rd=3 after edge 2; wb_rd=3 after edge 3; wb_rf_enable=0 after edge 4; pending_mask=0x0008 for 3 cycles.
- Load r5 then nop_insertion=1 for 1 cycle → ex_load_instruction=1 for one cycle, next EX is a bubble, bubble_count=1, and the re-presented instruction enters EX on the following edge.
- mem_busy=1 for 3 cycles with r2 in EX and r7 in MEM → ex_rd=2 and mem_rd=7 held, wb_rf_enable=0 after the first busy edge, pipe_freeze=1; flow resumes on release.
- flush=1 and nop_insertion=1 together, then flush alone → two bubbles, bubble_count increments only once.
- Force bubble_count to saturation (CNT_W=4, 20 load-use cycles) → count stays at 15.
- Assert reset_n low mid-stream between clock edges → all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipeline_dest_tracker.sv
// Destination-tag tracker for the hazards/forwarding unit.
//
// Carries each decoded instruction's destination register, register-file write
// enable and load flag through the EX, MEM and WB slots. It applies load-use NOP
// insertion, taken-branch flush and data-memory wait freezes to those slots. It
// also exports a mask of pending register writes and a saturating count of
// load-use bubbles.
//
// Ports
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   id_rd                   destination register decoded in ID
//   id_rf_enable, id_load   ID instruction writes the RF / is a load
//   id_valid                ID slot holds a real instruction
//   nop_insertion           load-use bubble request from the hazard unit
//   flush                   taken branch, kill the ID instruction
//   mem_busy                data memory not ready; freeze EX/MEM this cycle
//   ex_rd, ex_rf_enable, ex_load_instruction   EX-slot tag
//   mem_rd, mem_rf_enable                      MEM-slot tag
//   wb_rd, wb_rf_enable                        WB-slot tag
//   pending_mask            bit r set when any enabled slot targets register r
//   pipe_freeze             EX/MEM held this cycle (copy of mem_busy)
//   bubble_count            saturating count of load-use bubbles entering EX
module pipeline_dest_tracker #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rf_enable,
  input  logic                  id_load,
  input  logic                  id_valid,
  input  logic                  nop_insertion,
  input  logic                  flush,
  input  logic                  mem_busy,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_rf_enable,
  output logic                  ex_load_instruction,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_rf_enable,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_rf_enable,
  output logic [15:0]           pending_mask,
  output logic                  pipe_freeze,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam int unsigned NumRegs = 16;

  // Slot state
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_en_q, ex_en_d;
  logic                  ex_ld_q, ex_ld_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_en_q, mem_en_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_en_q, wb_en_d;
  logic [CNT_W-1:0]      bcnt_q, bcnt_d;

  logic ex_bubble;

  // flush and nop_insertion together still produce only one bubble.
  assign ex_bubble = nop_insertion | flush | ~id_valid;

  always_comb begin
    ex_rd_d  = ex_rd_q;
    ex_en_d  = ex_en_q;
    ex_ld_d  = ex_ld_q;
    mem_rd_d = mem_rd_q;
    mem_en_d = mem_en_q;
    wb_rd_d  = '0;
    wb_en_d  = 1'b0;
    bcnt_d   = bcnt_q;

    if (mem_busy) begin
      // EX and MEM hold; WB takes a bubble so the retiring write is seen once.
      // Upstream IF/ID is frozen too, so nop/flush re-appear next edge.
      wb_rd_d = '0;
      wb_en_d = 1'b0;
    end else begin
      if (ex_bubble) begin
        ex_rd_d = '0;
        ex_en_d = 1'b0;
        ex_ld_d = 1'b0;
      end else begin
        ex_rd_d = id_rd;
        ex_en_d = id_rf_enable;
        ex_ld_d = id_load;
      end
      // The load flag is only of interest in EX, so it is not carried further.
      mem_rd_d = ex_rd_q;
      mem_en_d = ex_en_q;
      wb_rd_d  = mem_rd_q;
      wb_en_d  = mem_en_q;
      // Only load-use bubbles are counted; the counter sticks at all-ones.
      if (nop_insertion && (bcnt_q != {CNT_W{1'b1}})) begin
        bcnt_d = bcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rd_q  <= '0;
      ex_en_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_en_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_en_q  <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_en_q  <= ex_en_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      mem_en_q <= mem_en_d;
      wb_rd_q  <= wb_rd_d;
      wb_en_q  <= wb_en_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // One-hot decode of each enabled slot, OR-ed together.
  always_comb begin
    pending_mask = '0;
    for (int unsigned r = 0; r < NumRegs; r++) begin
      if (ex_en_q && (ex_rd_q == REG_ADDR_W'(r))) pending_mask[r] = 1'b1;
      if (mem_en_q && (mem_rd_q == REG_ADDR_W'(r))) pending_mask[r] = 1'b1;
      if (wb_en_q && (wb_rd_q == REG_ADDR_W'(r))) pending_mask[r] = 1'b1;
    end
  end

  assign ex_rd               = ex_rd_q;
  assign ex_rf_enable        = ex_en_q;
  assign ex_load_instruction = ex_ld_q;
  assign mem_rd              = mem_rd_q;
  assign mem_rf_enable       = mem_en_q;
  assign wb_rd               = wb_rd_q;
  assign wb_rf_enable        = wb_en_q;
  assign pipe_freeze         = mem_busy;
  assign bubble_count        = bcnt_q;

endmodule
